// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the SDRAM port arbiter
//
// Purpose: FSM state enum, port identifiers and address width used by
//          sdram_port_arbiter and sdram_addr_gen.
// Ports:   none (package).
package sdram_arb_pkg;

  localparam int ADDR_W = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BURST = 2'd2
  } state_e;

  localparam logic [1:0] PORT_WR1 = 2'd0;
  localparam logic [1:0] PORT_RD1 = 2'd1;
  localparam logic [1:0] PORT_RD2 = 2'd2;

endpackage

// File: rtl/sdram_addr_gen.sv
// rtl/sdram_addr_gen.sv - per-port burst address counter with load, advance and wrap
//
// Purpose: holds one port's next burst address. load_i copies base_i,
//          adv_i steps by BURST_LEN and wraps to base_i once the step
//          would reach max_i. load_i wins over adv_i.
// Ports:
//   clk_i   in  1       clock
//   rst_ni  in  1       asynchronous active-low reset (already synchronised)
//   load_i  in  1       reload counter from base_i
//   adv_i   in  1       advance by one burst
//   base_i  in  ADDR_W  port base address
//   max_i   in  ADDR_W  port max address
//   addr_o  out ADDR_W  current burst start address
module sdram_addr_gen
  import sdram_arb_pkg::*;
#(
  parameter int BURST_LEN = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] max_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int SUM_W = ADDR_W + 1;
  localparam logic [SUM_W-1:0] STEP = SUM_W'(BURST_LEN);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SUM_W-1:0]  sum_w;

  always_comb begin
    // One extra bit so addr + BURST_LEN near the top of the space cannot
    // wrap around and slip under max_i.
    sum_w  = {1'b0, addr_q} + STEP;
    addr_d = addr_q;
    if (load_i) begin
      addr_d = base_i;
    end else if (adv_i) begin
      addr_d = (sum_w >= {1'b0, max_i}) ? base_i : sum_w[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - arbitrates refresh, one write and two read FIFO ports onto an SDRAM controller
//
// Purpose: in IDLE picks refresh > WR1 (fill >= BURST_LEN) > eligible reads,
//          presents a registered command until iCMD_ACK, waits for iDONE in
//          BURST, then advances the served port's address.
// Config:  SDRAM_ARB_ROUND_ROBIN_EN defined -> reads served round-robin;
//          undefined -> fixed priority RD1 > RD2 and no pointer logic.
// Ports:
//   iCLK, iRST_N                       clock, async active-low reset
//   iWR1_USEDW, iRD1_USEDW, iRD2_USEDW FIFO fill levels (10 bits)
//   iRD1_ACT, iRD2_ACT                 read port enables
//   iLOAD                              reload all addresses from bases
//   iWR1/RD1/RD2_ADDR, *_MAX_ADDR      port base / max addresses (23 bits)
//   iREF_REQ                           refresh request level
//   iCMD_ACK, iDONE                    controller accept / completion pulse
//   oCMD_REQ, oCMD_WR, oCMD_REF        command valid, write, refresh
//   oPORT_SEL, oADDR, oLEN             served port, start address, length
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BURST_LEN  = 128,
  parameter int FIFO_DEPTH = 512
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [9:0]        iWR1_USEDW,
  input  logic [9:0]        iRD1_USEDW,
  input  logic [9:0]        iRD2_USEDW,
  input  logic              iRD1_ACT,
  input  logic              iRD2_ACT,
  input  logic              iLOAD,
  input  logic [ADDR_W-1:0] iWR1_ADDR,
  input  logic [ADDR_W-1:0] iWR1_MAX_ADDR,
  input  logic [ADDR_W-1:0] iRD1_ADDR,
  input  logic [ADDR_W-1:0] iRD1_MAX_ADDR,
  input  logic [ADDR_W-1:0] iRD2_ADDR,
  input  logic [ADDR_W-1:0] iRD2_MAX_ADDR,
  input  logic              iREF_REQ,
  input  logic              iCMD_ACK,
  input  logic              iDONE,
  output logic              oCMD_REQ,
  output logic              oCMD_WR,
  output logic              oCMD_REF,
  output logic [1:0]        oPORT_SEL,
  output logic [ADDR_W-1:0] oADDR,
  output logic [8:0]        oLEN
);

  localparam logic [9:0] WR_LVL = 10'(BURST_LEN);
  localparam logic [9:0] RD_LVL = 10'(FIFO_DEPTH - BURST_LEN);

  // Asynchronous assert, synchronous release.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  state_e            state_q;
  logic              cmd_req_q, cmd_wr_q, cmd_ref_q;
  logic [1:0]        port_sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic              load_seen_q;

  logic [ADDR_W-1:0] wr1_addr, rd1_addr, rd2_addr;
  logic              adv_ok, adv_wr1, adv_rd1, adv_rd2;

  // Burst completion advances the served port unless it was a refresh or
  // iLOAD arrived during this burst (the reload already repositioned it).
  assign adv_ok  = (state_q == BURST) && iDONE && !cmd_ref_q && !load_seen_q && !iLOAD;
  assign adv_wr1 = adv_ok && (port_sel_q == PORT_WR1);
  assign adv_rd1 = adv_ok && (port_sel_q == PORT_RD1);
  assign adv_rd2 = adv_ok && (port_sel_q == PORT_RD2);

  sdram_addr_gen #(.BURST_LEN(BURST_LEN)) u_wr1_addr (
    .clk_i(iCLK), .rst_ni(rst_n), .load_i(iLOAD), .adv_i(adv_wr1),
    .base_i(iWR1_ADDR), .max_i(iWR1_MAX_ADDR), .addr_o(wr1_addr)
  );

  sdram_addr_gen #(.BURST_LEN(BURST_LEN)) u_rd1_addr (
    .clk_i(iCLK), .rst_ni(rst_n), .load_i(iLOAD), .adv_i(adv_rd1),
    .base_i(iRD1_ADDR), .max_i(iRD1_MAX_ADDR), .addr_o(rd1_addr)
  );

  sdram_addr_gen #(.BURST_LEN(BURST_LEN)) u_rd2_addr (
    .clk_i(iCLK), .rst_ni(rst_n), .load_i(iLOAD), .adv_i(adv_rd2),
    .base_i(iRD2_ADDR), .max_i(iRD2_MAX_ADDR), .addr_o(rd2_addr)
  );

  logic rd1_ok, rd2_ok, wr1_ok, pick_rd2;
  logic gnt_any_d, gnt_wr_d, gnt_ref_d;
  logic [1:0]        gnt_sel_d;
  logic [ADDR_W-1:0] gnt_addr_d;

  assign wr1_ok = (iWR1_USEDW >= WR_LVL);
  assign rd1_ok = iRD1_ACT && (iRD1_USEDW <= RD_LVL);
  assign rd2_ok = iRD2_ACT && (iRD2_USEDW <= RD_LVL);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_q;

  assign pick_rd2 = rd2_ok && (!rd1_ok || (rr_q == PORT_RD2));

  always_ff @(posedge iCLK or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= PORT_RD1;
    end else if ((state_q == IDLE) && gnt_any_d && !gnt_ref_d && !gnt_wr_d) begin
      rr_q <= (rr_q == PORT_RD1) ? PORT_RD2 : PORT_RD1;
    end
  end
`else
  assign pick_rd2 = rd2_ok && !rd1_ok;
`endif

  always_comb begin
    gnt_any_d  = 1'b0;
    gnt_wr_d   = 1'b0;
    gnt_ref_d  = 1'b0;
    gnt_sel_d  = PORT_WR1;
    gnt_addr_d = '0;
    // No grant while iLOAD is high, so a command never carries a stale
    // address from before the reload.
    if (!iLOAD) begin
      if (iREF_REQ) begin
        gnt_any_d = 1'b1;
        gnt_ref_d = 1'b1;
      end else if (wr1_ok) begin
        gnt_any_d  = 1'b1;
        gnt_wr_d   = 1'b1;
        gnt_sel_d  = PORT_WR1;
        gnt_addr_d = wr1_addr;
      end else if (pick_rd2) begin
        gnt_any_d  = 1'b1;
        gnt_sel_d  = PORT_RD2;
        gnt_addr_d = rd2_addr;
      end else if (rd1_ok) begin
        gnt_any_d  = 1'b1;
        gnt_sel_d  = PORT_RD1;
        gnt_addr_d = rd1_addr;
      end
    end
  end

  always_ff @(posedge iCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_req_q   <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_ref_q   <= 1'b0;
      port_sel_q  <= PORT_WR1;
      addr_q      <= '0;
      load_seen_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          load_seen_q <= 1'b0;
          if (gnt_any_d) begin
            state_q    <= ISSUE;
            cmd_req_q  <= 1'b1;
            cmd_wr_q   <= gnt_wr_d;
            cmd_ref_q  <= gnt_ref_d;
            port_sel_q <= gnt_sel_d;
            addr_q     <= gnt_addr_d;
          end
        end
        ISSUE: begin
          if (iLOAD) load_seen_q <= 1'b1;
          if (iCMD_ACK) begin
            cmd_req_q <= 1'b0;
            state_q   <= BURST;
          end
        end
        BURST: begin
          if (iLOAD) load_seen_q <= 1'b1;
          if (iDONE) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oCMD_REQ  = cmd_req_q;
  assign oCMD_WR   = cmd_wr_q;
  assign oCMD_REF  = cmd_ref_q;
  assign oPORT_SEL = port_sel_q;
  assign oADDR     = addr_q;
  assign oLEN      = 9'(BURST_LEN);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed scoreboard bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [9:0]  iWR1_USEDW, iRD1_USEDW, iRD2_USEDW;
  logic        iRD1_ACT, iRD2_ACT, iLOAD;
  logic [22:0] iWR1_ADDR, iWR1_MAX_ADDR, iRD1_ADDR, iRD1_MAX_ADDR, iRD2_ADDR, iRD2_MAX_ADDR;
  logic        iREF_REQ, iCMD_ACK, iDONE;
  logic        oCMD_REQ, oCMD_WR, oCMD_REF;
  logic [1:0]  oPORT_SEL;
  logic [22:0] oADDR;
  logic [8:0]  oLEN;

  sdram_port_arbiter dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iWR1_USEDW(iWR1_USEDW), .iRD1_USEDW(iRD1_USEDW), .iRD2_USEDW(iRD2_USEDW),
    .iRD1_ACT(iRD1_ACT), .iRD2_ACT(iRD2_ACT), .iLOAD(iLOAD),
    .iWR1_ADDR(iWR1_ADDR), .iWR1_MAX_ADDR(iWR1_MAX_ADDR),
    .iRD1_ADDR(iRD1_ADDR), .iRD1_MAX_ADDR(iRD1_MAX_ADDR),
    .iRD2_ADDR(iRD2_ADDR), .iRD2_MAX_ADDR(iRD2_MAX_ADDR),
    .iREF_REQ(iREF_REQ), .iCMD_ACK(iCMD_ACK), .iDONE(iDONE),
    .oCMD_REQ(oCMD_REQ), .oCMD_WR(oCMD_WR), .oCMD_REF(oCMD_REF),
    .oPORT_SEL(oPORT_SEL), .oADDR(oADDR), .oLEN(oLEN)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        is_ref;
    logic        wr;
    logic [1:0]  sel;
    logic [22:0] addr;
    bit          chk_addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [22:0] WR_B  = 23'd4096,   WR_M  = 23'd8192;
  localparam logic [22:0] RD1_B = 23'd8320,   RD1_M = 23'd100000;
  localparam logic [22:0] RD2_B = 23'd170880, RD2_M = 23'd324480;

  logic [22:0] wr_e, rd1_e, rd2_e;

  function automatic logic [22:0] nxt(input logic [22:0] a, input logic [22:0] b, input logic [22:0] m);
    logic [23:0] s;
    s = {1'b0, a} + 24'd128;
    if (s >= {1'b0, m}) return b;
    return s[22:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic r, input logic w, input logic [1:0] s, input logic [22:0] a, input bit c);
    exp_t e;
    e.is_ref = r; e.wr = w; e.sel = s; e.addr = a; e.chk_addr = c;
    sb.push_back(e);
  endtask

  // Acts as the SDRAM controller: waits for a command, checks it against
  // the scoreboard, holds ack low for 'hold' cycles, then ack and done.
  // load_mode: 0 none, 1 iLOAD one cycle before iDONE, 2 iLOAD with iDONE.
  task automatic serve(input string tag, input int hold, input int load_mode);
    exp_t e;
    int   n;
    n = 0;
    while (oCMD_REQ !== 1'b1 && n < 40) begin
      @(negedge iCLK);
      n++;
    end
    chk({tag, "_req"}, oCMD_REQ, 1);
    chk({tag, "_sb"}, sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_ref"}, oCMD_REF, e.is_ref);
      chk({tag, "_wr"}, oCMD_WR, e.wr);
      if (e.chk_addr) begin
        chk({tag, "_sel"}, oPORT_SEL, e.sel);
        chk({tag, "_addr"}, oADDR, e.addr);
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge iCLK);
        chk({tag, "_hold_req"}, oCMD_REQ, 1);
        if (e.chk_addr) chk({tag, "_hold_addr"}, oADDR, e.addr);
      end
    end
    iCMD_ACK = 1'b1;
    @(negedge iCLK);
    iCMD_ACK = 1'b0;
    chk({tag, "_req_drop"}, oCMD_REQ, 0);
    if (load_mode == 1) begin
      iLOAD = 1'b1;
      @(negedge iCLK);
      iLOAD = 1'b0;
    end
    iDONE = 1'b1;
    if (load_mode == 2) iLOAD = 1'b1;
    @(negedge iCLK);
    iDONE = 1'b0;
    iLOAD = 1'b0;
  endtask

  task automatic bases_to_model();
    wr_e = WR_B; rd1_e = RD1_B; rd2_e = RD2_B;
  endtask

  initial begin
    iRST_N = 1'b0;
    iWR1_USEDW = '0; iRD1_USEDW = '0; iRD2_USEDW = '0;
    iRD1_ACT = 1'b0; iRD2_ACT = 1'b0; iLOAD = 1'b0;
    iREF_REQ = 1'b0; iCMD_ACK = 1'b0; iDONE = 1'b0;
    iWR1_ADDR = WR_B;  iWR1_MAX_ADDR = WR_M;
    iRD1_ADDR = RD1_B; iRD1_MAX_ADDR = RD1_M;
    iRD2_ADDR = RD2_B; iRD2_MAX_ADDR = RD2_M;
    bases_to_model();

    repeat (3) @(negedge iCLK);
    chk("rst_req", oCMD_REQ, 0);
    chk("rst_wr", oCMD_WR, 0);
    chk("rst_ref", oCMD_REF, 0);
    chk("rst_sel", oPORT_SEL, 0);
    chk("rst_addr", oADDR, 0);
    chk("len", oLEN, 128);

    iRST_N = 1'b1;
    repeat (4) @(negedge iCLK);

    // First read right after load
    iRD1_ACT = 1'b1; iRD1_USEDW = '0; iLOAD = 1'b1;
    @(negedge iCLK);
    iLOAD = 1'b0;
    chk("load_lat0", oCMD_REQ, 0);
    @(negedge iCLK);
    chk("load_lat1", oCMD_REQ, 1);
    push(0, 0, 1, rd1_e, 1);
    serve("rd1_first", 0, 0);
    rd1_e = nxt(rd1_e, RD1_B, RD1_M);
    iRD1_ACT = 1'b0;

    // Stray ack/done in IDLE must not start or advance anything
    @(negedge iCLK);
    iCMD_ACK = 1'b1; iDONE = 1'b1;
    @(negedge iCLK);
    iCMD_ACK = 1'b0; iDONE = 1'b0;
    repeat (2) @(negedge iCLK);
    chk("stray_idle_req", oCMD_REQ, 0);

    // Refresh beats a simultaneous write; refresh leaves addresses alone
    iREF_REQ = 1'b1; iWR1_USEDW = 10'd200;
    @(negedge iCLK);
    iREF_REQ = 1'b0;
    push(1, 0, 0, 0, 0);
    serve("ref", 0, 0);
    push(0, 1, 0, wr_e, 1);
    serve("wr_a", 0, 0);
    wr_e = nxt(wr_e, WR_B, WR_M);
    push(0, 1, 0, wr_e, 1);
    serve("wr_b", 0, 0);
    wr_e = nxt(wr_e, WR_B, WR_M);
    iWR1_USEDW = 10'd127;
    repeat (3) @(negedge iCLK);
    chk("wr_127_idle", oCMD_REQ, 0);
    iWR1_USEDW = 10'd128;
    push(0, 1, 0, wr_e, 1);
    serve("wr_128", 0, 0);
    wr_e = nxt(wr_e, WR_B, WR_M);
    iWR1_USEDW = '0;

    // Read fill boundary, then 10-cycle ack stall
    iRD1_ACT = 1'b1; iRD1_USEDW = 10'd385;
    repeat (3) @(negedge iCLK);
    chk("rd_385_idle", oCMD_REQ, 0);
    iRD1_USEDW = 10'd384;
    push(0, 0, 1, rd1_e, 1);
    serve("rd1_stall", 10, 0);
    rd1_e = nxt(rd1_e, RD1_B, RD1_M);

    // iLOAD during a burst discards that burst's increment
    push(0, 0, 1, rd1_e, 1);
    serve("rd1_ld_pre", 0, 1);
    bases_to_model();
    push(0, 0, 1, rd1_e, 1);
    serve("rd1_after_ld", 0, 2);
    bases_to_model();
    push(0, 0, 1, rd1_e, 1);
    serve("rd1_after_ld2", 0, 0);
    rd1_e = nxt(rd1_e, RD1_B, RD1_M);
    iRD1_ACT = 1'b0; iRD1_USEDW = '0;

    // Second reset: counters return to 0 without a load
    @(negedge iCLK);
    iRST_N = 1'b0;
    @(negedge iCLK);
    chk("rst2_req", oCMD_REQ, 0);
    chk("rst2_addr", oADDR, 0);
    iRST_N = 1'b1;
    repeat (4) @(negedge iCLK);
    iWR1_USEDW = 10'd200;
    push(0, 1, 0, 0, 1);
    serve("wr_unloaded", 0, 0);
    iWR1_USEDW = '0;
    iLOAD = 1'b1;
    @(negedge iCLK);
    iLOAD = 1'b0;
    bases_to_model();

    // Both reads eligible
    iRD1_ACT = 1'b1; iRD2_ACT = 1'b1;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    push(0, 0, 1, RD1_B, 1);          serve("rr_1", 0, 0);
    push(0, 0, 2, RD2_B, 1);          serve("rr_2", 0, 0);
    push(0, 0, 1, RD1_B + 23'd128, 1); serve("rr_3", 0, 0);
    push(0, 0, 2, RD2_B + 23'd128, 1); serve("rr_4", 0, 0);
`else
    push(0, 0, 1, RD1_B, 1);          serve("fx_1", 0, 0);
    push(0, 0, 1, RD1_B + 23'd128, 1); serve("fx_2", 0, 0);
    push(0, 0, 1, RD1_B + 23'd256, 1); serve("fx_3", 0, 0);
`endif
    iRD1_ACT = 1'b0; iRD2_ACT = 1'b0;

    // RD2 walk through its whole window and wrap back to base
    @(negedge iCLK);
    iLOAD = 1'b1;
    @(negedge iCLK);
    iLOAD = 1'b0;
    iRD2_ACT = 1'b1;
    for (int i = 0; i < 1202; i++) begin
      push(0, 0, 2, RD2_B + 23'(128 * (i % 1200)), 1);
      serve("rd2_walk", 0, 0);
    end
    iRD2_ACT = 1'b0;
    repeat (2) @(negedge iCLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 128, words per SDRAM burst.
REQ-002 SHALL have parameter FIFO_DEPTH, default 512, words per port FIFO.
REQ-003 SHALL have ports:
- iCLK  in  1  system clock (TD_CLK27 domain); the block's only clock.
- iRST_N  in  1  asynchronous active-low reset.
- iWR1_USEDW  in  10  write FIFO fill level.
- iRD1_USEDW, iRD2_USEDW  in  10 each  read FIFO fill levels.
- iRD1_ACT, iRD2_ACT  in  1 each  read port enabled (odd/even field).
- iLOAD  in  1  reload all port addresses from base.
- iWR1_ADDR, iWR1_MAX_ADDR, iRD1_ADDR, iRD1_MAX_ADDR, iRD2_ADDR, iRD2_MAX_ADDR  in  23 each  port base and max addresses.
- iREF_REQ  in  1  refresh request, level.
- iCMD_ACK  in  1  command accepted by SDRAM controller.
- iDONE  in  1  one-cycle pulse at burst/refresh completion.
- oCMD_REQ  out  1  command valid.
- oCMD_WR  out  1  1 = write burst.
- oCMD_REF  out  1  1 = refresh command.
- oPORT_SEL  out  2  0 = WR1, 1 = RD1, 2 = RD2.
- oADDR  out  23  burst start address.
- oLEN  out  9  burst length, always BURST_LEN.

Function
REQ-004 SHALL implement states IDLE, ISSUE, BURST.
REQ-005 In IDLE, one arbitration per cycle SHALL apply this priority: refresh (iREF_REQ), then WR1 when iWR1_USEDW >= BURST_LEN, then eligible read ports.
REQ-006 A read port SHALL be eligible when its ACT = 1 and its USEDW <= FIFO_DEPTH - BURST_LEN.
REQ-007 On a grant, the block SHALL go IDLE->ISSUE and register oPORT_SEL, oADDR, oCMD_WR and oCMD_REF; oCMD_REQ SHALL rise the cycle after the decision.
REQ-008 In ISSUE, oCMD_REQ and all command fields SHALL stay stable until iCMD_ACK = 1; the next cycle oCMD_REQ = 0 and state = BURST.
REQ-009 In BURST, the block SHALL wait for iDONE, then return to IDLE, and SHALL issue no new command before reaching IDLE.
REQ-010 On iDONE of a data burst, the granted port's address SHALL advance by BURST_LEN.
REQ-011 The advanced address SHALL wrap to the port's base when addr + BURST_LEN >= MAX_ADDR.
REQ-012 A refresh SHALL not change any address.
REQ-013 iLOAD SHALL synchronously set all three address counters to their base inputs.
REQ-014 iLOAD does not abort a command in progress; the increment of that burst SHALL be discarded if iDONE coincides with or follows iLOAD within the same burst.
REQ-015 iACT deasserting mid-burst SHALL not abort the burst.
REQ-016 iCMD_ACK or iDONE outside ISSUE/BURST respectively SHALL be ignored.
REQ-017 Address arithmetic SHALL be 23-bit unsigned; the compare SHALL use 24 bits so it cannot overflow.
REQ-018 oLEN SHALL be constant BURST_LEN[8:0].

Reset
REQ-019 On iRST_N = 0: state = IDLE; oCMD_REQ = oCMD_WR = oCMD_REF = 0; oPORT_SEL = 0; oADDR = 0; address counters = 0.
REQ-020 The round-robin pointer SHALL reset to RD1.
REQ-021 Reset deassertion SHALL be synchronised internally; software must pulse iLOAD before use.

Configuration
REQ-022 Macro SDRAM_ARB_ROUND_ROBIN_EN:
- Defined: eligible read ports SHALL be served round-robin; the pointer toggles after each read grant.
- Undefined: fixed priority RD1 > RD2, and the pointer logic SHALL be absent.

Structure
REQ-023 Package sdram_arb_pkg SHALL hold the state enum, port ID constants (PORT_WR1/RD1/RD2) and ADDR_W = 23.
REQ-024 Sub-module sdram_addr_gen SHALL be the per-port counter with load, advance and wrap, instantiated three times.

Verification
REQ-025 Reset, iLOAD with iRD1_ADDR = 8320, iRD1_ACT = 1, iRD1_USEDW = 0 -> oCMD_REQ rises 2 cycles after reset release + load, oPORT_SEL = 1, oADDR = 8320, oCMD_WR = 0.
REQ-026 iREF_REQ = 1 and iWR1_USEDW = 200 in the same cycle -> first command oCMD_REF = 1; after iDONE, a write with oADDR = WR1 base.
REQ-027 RD2 base 170880, max 324480, repeated bursts -> addresses step by 128 and return to 170880 after the burst at 324352.
REQ-028 Both reads eligible with the macro defined -> grants alternate 1, 2, 1, 2; with the macro undefined -> 1, 1, 1.
REQ-029 iCMD_ACK held low for 10 cycles -> oCMD_REQ/oADDR stable all 10 cycles; iLOAD during BURST -> next RD1 oADDR = base.
